// File: rtl/fuec_codec_13_8_pkg.sv
// Shared definitions for the (13,8) Hsiao SEC-DED codec.
//   DATA_W / PAR_W / CW_W : fixed data, check and codeword widths
//   H_COL                 : parity-check matrix columns, indexed by codeword bit
//   dec_status_e          : decoder classification result
package fuec_13_8_pkg;

    localparam int DATA_W = 8;
    localparam int PAR_W  = 5;
    localparam int CW_W   = 13;

    // Column k is the syndrome produced when codeword bit k alone is flipped.
    // Codeword layout is {d[7:0], p[4:0]}, so bits 12..5 are d7..d0 and bits
    // 4..0 are the check bits (unit vectors). All data columns have odd weight
    // (3), which is what makes every double error land on an even-weight,
    // non-column syndrome.
    localparam logic [CW_W-1:0][PAR_W-1:0] H_COL = {
        5'b11001,  // bit 12 : d7
        5'b10110,  // bit 11 : d6
        5'b10101,  // bit 10 : d5
        5'b10011,  // bit  9 : d4
        5'b01110,  // bit  8 : d3
        5'b01101,  // bit  7 : d2
        5'b01011,  // bit  6 : d1
        5'b00111,  // bit  5 : d0
        5'b10000,  // bit  4 : p4
        5'b01000,  // bit  3 : p3
        5'b00100,  // bit  2 : p2
        5'b00010,  // bit  1 : p1
        5'b00001   // bit  0 : p0
    };

    typedef enum logic [1:0] {
        NO_ERR = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } dec_status_e;

endpackage

// File: rtl/fuec_codec_13_8_if.sv
// Request/result bundle for the (13,8) codec.
// Handshake: valid-only, no ready. A request is taken on every rising clk edge
// where its *_valid_i is 1; the matching *_valid_o pulses exactly one cycle
// later. Result data buses hold their last value while *_valid_o is 0.
//   slave  : codec side (takes requests, drives results)
//   master : user side (drives requests, takes results)
interface fuec_codec_13_8_if;
    import fuec_13_8_pkg::*;

    logic              enc_valid_i;
    logic [DATA_W-1:0] enc_data_i;
    logic              enc_valid_o;
    logic [PAR_W-1:0]  enc_parity_o;
    logic [CW_W-1:0]   enc_cw_o;

    logic              dec_valid_i;
    logic [CW_W-1:0]   dec_cw_i;
    logic              dec_valid_o;
    logic [PAR_W-1:0]  dec_syndrome_o;
    logic [CW_W-1:0]   dec_cw_fix_o;
    logic [DATA_W-1:0] dec_data_o;
    logic              dec_no_error_o;
    logic              dec_corrected_o;
    logic              dec_uncorrectable_o;

    modport slave (
        input  enc_valid_i, enc_data_i, dec_valid_i, dec_cw_i,
        output enc_valid_o, enc_parity_o, enc_cw_o,
               dec_valid_o, dec_syndrome_o, dec_cw_fix_o, dec_data_o,
               dec_no_error_o, dec_corrected_o, dec_uncorrectable_o
    );

    modport master (
        output enc_valid_i, enc_data_i, dec_valid_i, dec_cw_i,
        input  enc_valid_o, enc_parity_o, enc_cw_o,
               dec_valid_o, dec_syndrome_o, dec_cw_fix_o, dec_data_o,
               dec_no_error_o, dec_corrected_o, dec_uncorrectable_o
    );

endinterface

// File: rtl/fuec_codec_13_8_parity_gen.sv
// Combinational check-bit generator for the (13,8) Hsiao code.
//   d : data word d[7:0]
//   p : check bits p[4:0]; p[j] is the XOR of every data bit whose H column
//       has bit j set.
module fuec_parity_gen_13_8
    import fuec_13_8_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic [PAR_W-1:0]  p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (d[i]) begin
                p = p ^ H_COL[i + PAR_W];
            end
        end
    end

endmodule

// File: rtl/fuec_codec_13_8.sv
// Registered (13,8) SEC-DED codec: independent 1-cycle encode and decode
// pipelines sharing one clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every output
//   bus   : request/result bundle (slave side)
//             encode: enc_data_i -> enc_parity_o, enc_cw_o = {d, p}
//             decode: dec_cw_i   -> syndrome, corrected codeword/data and
//                     exactly one of no_error / corrected / uncorrectable
module fuec_codec_13_8
    import fuec_13_8_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    fuec_codec_13_8_if.slave bus
);

    logic [PAR_W-1:0]  enc_par;
    logic [PAR_W-1:0]  dec_par;
    logic [PAR_W-1:0]  syn;
    logic [CW_W-1:0]   flip_mask;
    dec_status_e       status;

    logic              enc_valid_q;
    logic [PAR_W-1:0]  enc_par_q;
    logic [CW_W-1:0]   enc_cw_q;
    logic              dec_valid_q;
    logic [PAR_W-1:0]  dec_syn_q;
    logic [CW_W-1:0]   dec_fix_q;
    logic              no_err_q;
    logic              corr_q;
    logic              uncorr_q;

    fuec_parity_gen_13_8 u_enc_pgen (
        .d (bus.enc_data_i),
        .p (enc_par)
    );

    // Recomputing parity over the received data and XORing with the received
    // check bits gives the syndrome directly.
    fuec_parity_gen_13_8 u_dec_pgen (
        .d (bus.dec_cw_i[CW_W-1:PAR_W]),
        .p (dec_par)
    );

    assign syn = dec_par ^ bus.dec_cw_i[PAR_W-1:0];

    // A nonzero syndrome that matches no column (even weight, or one of the
    // unused odd-weight patterns) is left uncorrected.
    always_comb begin
        flip_mask = '0;
        status    = NO_ERR;
        if (syn != '0) begin
            status = UNCORR;
            for (int k = 0; k < CW_W; k++) begin
                if (syn == H_COL[k]) begin
                    flip_mask[k] = 1'b1;
                    status       = CORR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid_q <= 1'b0;
            enc_par_q   <= '0;
            enc_cw_q    <= '0;
        end else begin
            enc_valid_q <= bus.enc_valid_i;
            if (bus.enc_valid_i) begin
                enc_par_q <= enc_par;
                enc_cw_q  <= {bus.enc_data_i, enc_par};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_q <= 1'b0;
            dec_syn_q   <= '0;
            dec_fix_q   <= '0;
            no_err_q    <= 1'b0;
            corr_q      <= 1'b0;
            uncorr_q    <= 1'b0;
        end else begin
            dec_valid_q <= bus.dec_valid_i;
            if (bus.dec_valid_i) begin
                dec_syn_q <= syn;
                dec_fix_q <= bus.dec_cw_i ^ flip_mask;
                no_err_q  <= (status == NO_ERR);
                corr_q    <= (status == CORR);
                uncorr_q  <= (status == UNCORR);
            end
        end
    end

    assign bus.enc_valid_o         = enc_valid_q;
    assign bus.enc_parity_o        = enc_par_q;
    assign bus.enc_cw_o            = enc_cw_q;
    assign bus.dec_valid_o         = dec_valid_q;
    assign bus.dec_syndrome_o      = dec_syn_q;
    assign bus.dec_cw_fix_o        = dec_fix_q;
    assign bus.dec_data_o          = dec_fix_q[CW_W-1:PAR_W];
    assign bus.dec_no_error_o      = no_err_q;
    assign bus.dec_corrected_o     = corr_q;
    assign bus.dec_uncorrectable_o = uncorr_q;

endmodule

// File: tb/tb_fuec_codec_13_8.sv
// Self-checking bench for fuec_codec_13_8: directed vectors, exhaustive
// single/double-flip round trip, randomized traffic and a mid-operation reset,
// all scored against a reference model built from the parity equations.
module tb_fuec_codec_13_8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fuec_codec_13_8_if ifc ();

    fuec_codec_13_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] model_par(input logic [7:0] d);
        logic [4:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return p;
    endfunction

    function automatic logic [4:0] model_syn(input logic [12:0] r);
        return model_par(r[12:5]) ^ r[4:0];
    endfunction

    // Returns {syndrome[4:0], fixed_cw[12:0], no_err, corr, uncorr}.
    // Correction is found by searching for the single flip that yields a
    // valid codeword.
    function automatic logic [20:0] model_dec(input logic [12:0] r);
        logic [4:0]  s;
        logic [12:0] t;
        s = model_syn(r);
        if (s == 5'd0) return {s, r, 3'b100};
        for (int k = 0; k < 13; k++) begin
            t = r;
            t[k] = ~t[k];
            if (model_syn(t) == 5'd0) return {s, t, 3'b010};
        end
        return {s, r, 3'b001};
    endfunction

    // ---------------- scoreboard ----------------
    logic [17:0] enc_q[$];   // {parity, cw}
    logic [20:0] dec_q[$];
    logic [17:0] last_enc;
    logic [20:0] last_dec;
    logic        mon_en;
    logic        ev_s;
    logic        dv_s;

    always @(posedge clk) begin
        ev_s = ifc.enc_valid_i;
        dv_s = ifc.dec_valid_i;
        if (mon_en && rst_n) begin
            #1;
            check("enc_valid", ifc.enc_valid_o, ev_s);
            if (ev_s && enc_q.size() > 0) last_enc = enc_q.pop_front();
            check("enc_parity", ifc.enc_parity_o, last_enc[17:13]);
            check("enc_cw", ifc.enc_cw_o, last_enc[12:0]);
            check("dec_valid", ifc.dec_valid_o, dv_s);
            if (dv_s && dec_q.size() > 0) last_dec = dec_q.pop_front();
            check("dec_syndrome", ifc.dec_syndrome_o, last_dec[20:16]);
            check("dec_cw_fix", ifc.dec_cw_fix_o, last_dec[15:3]);
            check("dec_data", ifc.dec_data_o, last_dec[15:8]);
            check("dec_flags", {ifc.dec_no_error_o, ifc.dec_corrected_o, ifc.dec_uncorrectable_o},
                  last_dec[2:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ev, input logic [7:0] ed, input logic dv, input logic [12:0] dcw);
        logic [4:0] p;
        @(negedge clk);
        ifc.enc_valid_i = ev;
        ifc.enc_data_i  = ed;
        ifc.dec_valid_i = dv;
        ifc.dec_cw_i    = dcw;
        p = model_par(ed);
        if (ev) enc_q.push_back({p, ed, p});
        if (dv) dec_q.push_back(model_dec(dcw));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0, 13'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enc_valid"}, ifc.enc_valid_o, 0);
        check({tag, "_enc_parity"}, ifc.enc_parity_o, 0);
        check({tag, "_enc_cw"}, ifc.enc_cw_o, 0);
        check({tag, "_dec_valid"}, ifc.dec_valid_o, 0);
        check({tag, "_dec_syn"}, ifc.dec_syndrome_o, 0);
        check({tag, "_dec_fix"}, ifc.dec_cw_fix_o, 0);
        check({tag, "_dec_data"}, ifc.dec_data_o, 0);
        check({tag, "_dec_flags"}, {ifc.dec_no_error_o, ifc.dec_corrected_o, ifc.dec_uncorrectable_o}, 0);
    endtask

    // Directed decode: drive one request, then compare against fixed values.
    task automatic dir_dec(input string tag, input logic [12:0] cw, input logic [4:0] syn,
                           input logic [12:0] fix, input logic [2:0] flags);
        drive(1'b0, 8'h00, 1'b1, cw);
        @(posedge clk);
        #2;
        check({tag, "_syn"}, ifc.dec_syndrome_o, syn);
        check({tag, "_fix"}, ifc.dec_cw_fix_o, fix);
        check({tag, "_data"}, ifc.dec_data_o, fix[12:5]);
        check({tag, "_flags"}, {ifc.dec_no_error_o, ifc.dec_corrected_o, ifc.dec_uncorrectable_o}, flags);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [12:0] cw;
        logic [12:0] t;
        logic [7:0]  d;
        int          nflip;

        mon_en   = 1'b0;
        last_enc = '0;
        last_dec = '0;
        rst_n    = 1'b0;
        // Requests during reset must not be captured.
        ifc.enc_valid_i = 1'b1;
        ifc.enc_data_i  = 8'hFF;
        ifc.dec_valid_i = 1'b1;
        ifc.dec_cw_i    = 13'h1FFF;
        repeat (3) @(negedge clk);
        check_all_zero("rst");

        ifc.enc_valid_i = 1'b0;
        ifc.dec_valid_i = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(3);
        @(posedge clk);
        #2;
        check_all_zero("post_rst");

        // Directed encode plus clean decode in the same cycle.
        drive(1'b1, 8'b10101100, 1'b1, 13'h158F);
        @(posedge clk);
        #2;
        check("dir_enc_parity", ifc.enc_parity_o, 5'b01111);
        check("dir_enc_cw", ifc.enc_cw_o, 13'h158F);
        check("dir_enc_valid", ifc.enc_valid_o, 1);
        check("dir_clean_syn", ifc.dec_syndrome_o, 0);
        check("dir_clean_noerr", ifc.dec_no_error_o, 1);
        check("dir_clean_data", ifc.dec_data_o, 8'hAC);

        dir_dec("dir_d0flip", 13'h15AF, 5'b00111, 13'h158F, 3'b010);
        dir_dec("dir_p0flip", 13'h158E, 5'b00001, 13'h158F, 3'b010);
        dir_dec("dir_double", 13'h15AE, 5'b00110, 13'h15AE, 3'b001);
        idle(2);

        // Round trip: every data word, clean, all single and all double flips,
        // back-to-back with a random encode running alongside.
        for (int v = 0; v < 256; v++) begin
            d  = 8'(v);
            cw = {d, model_par(d)};
            drive(1'b1, d, 1'b1, cw);
            for (int i = 0; i < 13; i++) begin
                t = cw;
                t[i] = ~t[i];
                drive(1'b1, 8'($urandom), 1'b1, t);
            end
            for (int i = 0; i < 13; i++) begin
                for (int j = i + 1; j < 13; j++) begin
                    t = cw;
                    t[i] = ~t[i];
                    t[j] = ~t[j];
                    drive(1'b1, 8'($urandom), 1'b1, t);
                end
            end
        end
        idle(3);

        // Randomized traffic with gaps; invalid cycles carry junk that must not land.
        for (int n = 0; n < 3000; n++) begin
            d  = 8'($urandom);
            cw = {d, model_par(d)};
            nflip = $urandom_range(0, 3);
            for (int f = 0; f < nflip; f++) begin
                t = cw;
                t[$urandom_range(0, 12)] = ~t[$urandom_range(0, 12)];
                cw = t;
            end
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 13'($urandom) : cw);
        end

        // Reset arriving while a request is in flight.
        @(negedge clk);
        mon_en = 1'b0;
        ifc.enc_valid_i = 1'b1;
        ifc.enc_data_i  = 8'h5A;
        ifc.dec_valid_i = 1'b1;
        ifc.dec_cw_i    = 13'h1ABC;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        ifc.enc_valid_i = 1'b0;
        ifc.dec_valid_i = 1'b0;
        enc_q.delete();
        dec_q.delete();
        last_enc = '0;
        last_dec = '0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);
        for (int n = 0; n < 200; n++) begin
            d = 8'($urandom);
            drive(1'b1, d, 1'b1, {d, model_par(d)} ^ (13'd1 << $urandom_range(0, 12)));
        end
        idle(3);
        @(posedge clk);
        #2;

        check("enc_q_drained", enc_q.size(), 0);
        check("dec_q_drained", dec_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
